alu_selfcheck: RTL

- Synthesizable stimulus generator and result checker for two ALU implementations with the same port set (a_in, b_in, sel_in -> q_out), e.g. gate-level and behavioural.
- Drives identical pseudo-random operands and cycling opcodes to both ALUs and compares their q_out values every cycle.
- Counts mismatches and records the index of the first one.
- Sits on the driving/checking side of the ALU interface, so equivalence checks can run in hardware or emulation without a simulator bench.

---
 rtl/alu_selfcheck.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_selfcheck.sv
// Stimulus generator and equivalence checker for two ALUs that share one port set.
// Both ALUs receive the same pseudo-random operands and a cycling opcode.
// Their results are compared one cycle later, and the mismatches are counted.
module alu_selfcheck #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned NUM_VECTORS = 50,
  parameter int unsigned IDX_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  output logic [DATA_WIDTH-1:0]   a_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  output logic [2:0]              sel_out,
  input  logic [2*DATA_WIDTH-1:0] q0_in,
  input  logic [2*DATA_WIDTH-1:0] q1_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [CNT_WIDTH-1:0]    err_count_out,
  output logic                    err_flag_out,
  output logic [IDX_WIDTH-1:0]    first_err_idx_out
);

  localparam logic [15:0]          SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]              sel_q, sel_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    flag_q, flag_d;
  logic [IDX_WIDTH-1:0]    first_q, first_d;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // lfsr_q always holds the value for the next vector to apply, so the vector in flight is a_q/b_q.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    first_d = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = RUN;
          a_d     = SEED_EFF[DATA_WIDTH-1:0];
          b_d     = SEED_EFF[2*DATA_WIDTH-1:DATA_WIDTH];
          lfsr_d  = lfsr_next(SEED_EFF);
          sel_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          flag_d  = 1'b0;
          first_d = '0;
        end
      end
      RUN: begin
        if (q0_in != q1_in) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          if (!flag_q) begin
            flag_d  = 1'b1;
            first_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          a_d    = lfsr_q[DATA_WIDTH-1:0];
          b_d    = lfsr_q[2*DATA_WIDTH-1:DATA_WIDTH];
          lfsr_d = lfsr_next(lfsr_q);
          sel_d  = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
          idx_d  = idx_q + IDX_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      first_q <= first_d;
    end
  end

  assign a_out             = a_q;
  assign b_out             = b_q;
  assign sel_out           = sel_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign err_count_out     = cnt_q;
  assign err_flag_out      = flag_q;
  assign first_err_idx_out = first_q;

endmodule
